// File: rtl/mux_scan_sel.sv
// mux_scan_sel -- N-channel, W-bit registered selector with manual select,
// auto-scan rotation with a programmable dwell, and a freeze control.
//
// Optional feature macro: MUX_SCAN_CHG_EN adds the `chg` output, a one-cycle
// pulse whenever the registered data value changes.
//
// Parameters:
//   W    data width per channel
//   N    channel count (>= 2, any value)
//   DIV  scan dwell in active cycles per channel (>= 1)
// Ports:
//   clk       sole clock, rising edge
//   rst_n     asynchronous active-low reset
//   din       packed channels, channel i at din[i*W +: W]
//   sel       manual channel select
//   mode      0 = manual, 1 = auto-scan
//   hold      1 = freeze all state and outputs
//   dout      registered selected data
//   dout_ch   channel index dout came from
//   dout_vld  dout holds a valid channel
//   chg       data-change pulse (only with MUX_SCAN_CHG_EN)
module mux_scan_sel #(
   parameter int W   = 2,
   parameter int N   = 4,
   parameter int DIV = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N*W-1:0]        din,
   input  logic [$clog2(N)-1:0]  sel,
   input  logic                  mode,
   input  logic                  hold,
   output logic [W-1:0]          dout,
   output logic [$clog2(N)-1:0]  dout_ch,
   output logic                  dout_vld
`ifdef MUX_SCAN_CHG_EN
   ,
   output logic                  chg
`endif
);

   localparam int SW = $clog2(N);
   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   // Channel table is padded to a power of two so any SW-bit index is legal.
   localparam int NP = 1 << SW;
   localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);
   localparam logic [SW-1:0] CH_ONE  = SW'(1'b1);

   logic [W-1:0]  ch_data_s [NP];
   logic [W-1:0]  dout_r,     dout_nx_s;
   logic [SW-1:0] dout_ch_r,  dout_ch_nx_s;
   logic          dout_vld_r, dout_vld_nx_s;
   logic [SW-1:0] ch_r,       ch_nx_s;
   logic [CW-1:0] cnt_r,      cnt_nx_s;
   logic          sel_ok_s;
   logic          ch_last_s;
   logic          cnt_last_s;

   // Unused padding entries read as zero, which is also the out-of-range data value.
   for (genvar g = 0; g < NP; g++) begin : g_ch
      if (g < N) begin : g_used
         assign ch_data_s[g] = din[g*W +: W];
      end else begin : g_pad
         assign ch_data_s[g] = {W{1'b0}};
      end
   end

   assign sel_ok_s   = (int'(sel)   <  N);
   assign ch_last_s  = (int'(ch_r)  == N - 1);
   assign cnt_last_s = (int'(cnt_r) == DIV - 1);

   // Next-state selection for data, index, valid, scan channel and dwell counter.
   always_comb begin
      dout_nx_s     = dout_r;
      dout_ch_nx_s  = dout_ch_r;
      dout_vld_nx_s = dout_vld_r;
      ch_nx_s       = ch_r;
      cnt_nx_s      = cnt_r;
      if (hold) begin
         // Frozen: hold cycles do not consume dwell.
         dout_nx_s     = dout_r;
         dout_ch_nx_s  = dout_ch_r;
         dout_vld_nx_s = dout_vld_r;
         ch_nx_s       = ch_r;
         cnt_nx_s      = cnt_r;
      end else if (!mode) begin
         dout_ch_nx_s = sel;
         cnt_nx_s     = {CW{1'b0}};
         if (sel_ok_s) begin
            dout_nx_s     = ch_data_s[sel];
            dout_vld_nx_s = 1'b1;
            ch_nx_s       = sel;
         end else begin
            // Keep ch so a later scan resumes from the last valid channel.
            dout_nx_s     = {W{1'b0}};
            dout_vld_nx_s = 1'b0;
            ch_nx_s       = ch_r;
         end
      end else begin
         dout_nx_s     = ch_data_s[ch_r];
         dout_ch_nx_s  = ch_r;
         dout_vld_nx_s = 1'b1;
         if (cnt_last_s) begin
            cnt_nx_s = {CW{1'b0}};
            ch_nx_s  = ch_last_s ? {SW{1'b0}} : (ch_r + CH_ONE);
         end else begin
            cnt_nx_s = cnt_r + CNT_ONE;
            ch_nx_s  = ch_r;
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout_r     <= {W{1'b0}};
         dout_ch_r  <= {SW{1'b0}};
         dout_vld_r <= 1'b0;
         ch_r       <= {SW{1'b0}};
         cnt_r      <= {CW{1'b0}};
      end else begin
         dout_r     <= dout_nx_s;
         dout_ch_r  <= dout_ch_nx_s;
         dout_vld_r <= dout_vld_nx_s;
         ch_r       <= ch_nx_s;
         cnt_r      <= cnt_nx_s;
      end
   end

   assign dout     = dout_r;
   assign dout_ch  = dout_ch_r;
   assign dout_vld = dout_vld_r;

`ifdef MUX_SCAN_CHG_EN
   logic chg_r;
   logic chg_nx_s;

   // Change pulse compares the value about to be registered with the current one.
   always_comb begin
      chg_nx_s = 1'b0;
      if (hold) begin
         chg_nx_s = 1'b0;
      end else begin
         chg_nx_s = (dout_nx_s != dout_r);
      end
   end

   // Change pulse register, aligned with the dout update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chg_r <= 1'b0;
      end else begin
         chg_r <= chg_nx_s;
      end
   end

   assign chg = chg_r;
`endif

endmodule

// File: tb/tb_mux_scan_sel.sv
// Self-checking bench for mux_scan_sel. Two instances run side by side:
// u0 uses the default shape (W=2, N=4, DIV=4); u1 uses W=3, N=3, DIV=2 so
// that out-of-range selects and a non-power-of-two rotation are exercised.
module tb_mux_scan_sel;

   localparam int W0 = 2, N0 = 4, D0 = 4, S0 = 2;
   localparam int W1 = 3, N1 = 3, D1 = 2, S1 = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [N0*W0-1:0]  din0 = 8'hE4;
   logic [N1*W1-1:0]  din1 = {3'd5, 3'd6, 3'd7};
   logic [S0-1:0]     sel0 = 2'd0;
   logic [S1-1:0]     sel1 = 2'd0;
   logic              mode = 1'b0;
   logic              hold = 1'b0;
   logic [W0-1:0]     dout0;
   logic [S0-1:0]     dch0;
   logic              vld0;
   logic [W1-1:0]     dout1;
   logic [S1-1:0]     dch1;
   logic              vld1;
`ifdef MUX_SCAN_CHG_EN
   logic              chg0;
   logic              chg1;
`endif

   always #5 clk = ~clk;

   mux_scan_sel #(.W(W0), .N(N0), .DIV(D0)) u0 (
      .clk(clk), .rst_n(rst_n), .din(din0), .sel(sel0), .mode(mode), .hold(hold),
      .dout(dout0), .dout_ch(dch0), .dout_vld(vld0)
`ifdef MUX_SCAN_CHG_EN
      , .chg(chg0)
`endif
   );

   mux_scan_sel #(.W(W1), .N(N1), .DIV(D1)) u1 (
      .clk(clk), .rst_n(rst_n), .din(din1), .sel(sel1), .mode(mode), .hold(hold),
      .dout(dout1), .dout_ch(dch1), .dout_vld(vld1)
`ifdef MUX_SCAN_CHG_EN
      , .chg(chg1)
`endif
   );

   typedef struct packed {
      logic [31:0] d0, c0, v0, g0, d1, c1, v1, g1;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: the channel on display and how many active cycles it has shown.
   int m_ch[2], m_shown[2], m_dout[2], m_dch[2], m_vld[2], m_chg[2];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int nch(input int k);
      return (k == 0) ? N0 : N1;
   endfunction

   function automatic int dwell(input int k);
      return (k == 0) ? D0 : D1;
   endfunction

   function automatic int chan(input int k, input int c);
      logic [31:0] v;
      int          w;
      v = (k == 0) ? 32'(din0) : 32'(din1);
      w = (k == 0) ? W0 : W1;
      return int'((v >> (c * w)) & ((32'd1 << w) - 32'd1));
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_ch[k] = 0; m_shown[k] = 0; m_dout[k] = 0;
         m_dch[k] = 0; m_vld[k] = 0; m_chg[k] = 0;
      end
   endtask

   task automatic model_step(input int k, input int s);
      int nd;
      if (hold) begin
         m_chg[k] = 0;
      end else begin
         if (!mode) begin
            m_dch[k]   = s;
            m_shown[k] = 0;
            if (s < nch(k)) begin
               nd = chan(k, s); m_vld[k] = 1; m_ch[k] = s;
            end else begin
               nd = 0; m_vld[k] = 0;
            end
         end else begin
            nd = chan(k, m_ch[k]);
            m_dch[k] = m_ch[k];
            m_vld[k] = 1;
            m_shown[k]++;
            if (m_shown[k] == dwell(k)) begin
               m_shown[k] = 0;
               m_ch[k] = (m_ch[k] + 1) % nch(k);
            end
         end
         m_chg[k]  = (nd != m_dout[k]) ? 1 : 0;
         m_dout[k] = nd;
      end
   endtask

   task automatic push_exp();
      exp_t e;
      e.d0 = m_dout[0]; e.c0 = m_dch[0]; e.v0 = m_vld[0]; e.g0 = m_chg[0];
      e.d1 = m_dout[1]; e.c1 = m_dch[1]; e.v1 = m_vld[1]; e.g1 = m_chg[1];
      exp_q.push_back(e);
   endtask

   task automatic drive(input logic m, input logic h, input int s0, input int s1,
                        input logic [N0*W0-1:0] d0, input logic [N1*W1-1:0] d1);
      @(negedge clk);
      rst_n = 1'b1;
      mode = m; hold = h;
      sel0 = S0'(s0); sel1 = S1'(s1);
      din0 = d0; din1 = d1;
      model_step(0, s0);
      model_step(1, s1);
      push_exp();
   endtask

   // Asynchronous reset between edges: outputs must clear before any edge.
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_dout0", int'(dout0), 0);
      chk("rst_ch0",   int'(dch0),  0);
      chk("rst_vld0",  int'(vld0),  0);
      chk("rst_dout1", int'(dout1), 0);
      chk("rst_ch1",   int'(dch1),  0);
      chk("rst_vld1",  int'(vld1),  0);
`ifdef MUX_SCAN_CHG_EN
      chk("rst_chg0",  int'(chg0),  0);
      chk("rst_chg1",  int'(chg1),  0);
`endif
      model_reset();
      push_exp();
   endtask

   // Monitor: after every rising edge, compare the DUT outputs with the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("dout0", int'(dout0), int'(e.d0));
            chk("ch0",   int'(dch0),  int'(e.c0));
            chk("vld0",  int'(vld0),  int'(e.v0));
            chk("dout1", int'(dout1), int'(e.d1));
            chk("ch1",   int'(dch1),  int'(e.c1));
            chk("vld1",  int'(vld1),  int'(e.v1));
`ifdef MUX_SCAN_CHG_EN
            chk("chg0",  int'(chg0),  int'(e.g0));
            chk("chg1",  int'(chg1),  int'(e.g1));
`endif
         end
      end
   end

   // Stimulus: directed scenarios first, then randomized traffic.
   initial begin
      logic              rm;
      logic [N0*W0-1:0]  r0;
      logic [N1*W1-1:0]  r1;
      logic [N0*W0-1:0]  kd0;
      logic [N1*W1-1:0]  kd1;
      kd0 = 8'hE4;                      // ch3..ch0 = 3,2,1,0
      kd1 = {3'd5, 3'd6, 3'd7};         // ch2..ch0 = 5,6,7
      model_reset();
      repeat (2) @(negedge clk);

      // Manual select.
      drive(1'b0, 1'b0, 2, 1, kd0, kd1);
      drive(1'b0, 1'b0, 0, 2, kd0, kd1);

      // Full scan from channel 0, one edge past a rotation.
      do_reset();
      repeat (17) drive(1'b1, 1'b0, 0, 0, kd0, kd1);

      // Reset mid-scan, then hold with channel 1 two cycles into its dwell.
      repeat (5) drive(1'b1, 1'b0, 0, 0, kd0, kd1);
      do_reset();
      repeat (6) drive(1'b1, 1'b0, 0, 0, kd0, kd1);
      repeat (3) drive(1'b1, 1'b1, 0, 0, kd0, kd1);
      repeat (6) drive(1'b1, 1'b0, 0, 0, kd0, kd1);

      // Reset mid-hold.
      repeat (2) drive(1'b1, 1'b1, 0, 0, kd0, kd1);
      do_reset();
      repeat (3) drive(1'b1, 1'b0, 0, 0, kd0, kd1);

      // Out-of-range select on the three-channel instance, then resume scanning.
      drive(1'b0, 1'b0, 1, 1, kd0, kd1);
      repeat (2) drive(1'b0, 1'b0, 1, 3, kd0, kd1);
      repeat (5) drive(1'b1, 1'b0, 0, 0, kd0, kd1);

      // Change pulse: ch1=1, ch2=2, ch3=2.
      kd0 = 8'hA4;
      drive(1'b0, 1'b0, 1, 0, kd0, kd1);
      drive(1'b0, 1'b0, 2, 0, kd0, kd1);
      drive(1'b0, 1'b0, 3, 0, kd0, kd1);
      drive(1'b0, 1'b0, 3, 0, kd0, kd1);

      // Randomized traffic with occasional resets.
      rm = 1'b0; r0 = kd0; r1 = kd1;
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 59) == 0) begin
            do_reset();
         end else begin
            if ($urandom_range(0, 15) == 0) rm = ~rm;
            if ($urandom_range(0, 3) == 0) r0 = N0*W0'($urandom);
            if ($urandom_range(0, 3) == 0) r1 = N1*W1'($urandom);
            drive(rm, ($urandom_range(0, 5) == 0), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), r0, r1);
         end
      end

      repeat (2) @(negedge clk);
      chk("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
